// File: rtl/mips_pkg.sv
// Shared decode constants and control bundle for the MIPS execute slice.
package mips_pkg;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'b000000,
        OP_J     = 6'b000010,
        OP_BEQ   = 6'b000100,
        OP_ADDI  = 6'b001000,
        OP_LW    = 6'b100011,
        OP_SW    = 6'b101011
    } opcode_e;

    typedef enum logic [5:0] {
        FN_ADD = 6'b100000,
        FN_SUB = 6'b100010,
        FN_AND = 6'b100100,
        FN_OR  = 6'b100101,
        FN_SLT = 6'b101010
    } funct_e;

    typedef enum logic [2:0] {
        ALU_AND  = 3'b000,
        ALU_OR   = 3'b001,
        ALU_ADD  = 3'b010,
        ALU_ZERO = 3'b011,
        ALU_ANDN = 3'b100,
        ALU_ORN  = 3'b101,
        ALU_SUB  = 3'b110,
        ALU_SLT  = 3'b111
    } alu_ctrl_e;

    typedef struct packed {
        logic      reg_wr_en;
        logic      rd_sel;
        logic      alu_src;
        logic      mem_wr;
        logic      mem_to_reg;
        logic      branch;
        logic      jump;
        alu_ctrl_e alu_ctrl;
    } ctrl_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU with zero flag; arithmetic wraps, no overflow detection.
module alu
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH_P      = 32,
    parameter int ALU_CNTRL_WIDTH_P = 3
) (
    input  logic [DATA_WIDTH_P-1:0]      a_i,
    input  logic [DATA_WIDTH_P-1:0]      b_i,
    input  logic [ALU_CNTRL_WIDTH_P-1:0] ctrl_i,
    output logic [DATA_WIDTH_P-1:0]      result_o,
    output logic                         zero_o
);

    logic slt;

    assign slt = ($signed(a_i) < $signed(b_i));

    always_comb begin
        result_o = '0;
        case (ctrl_i)
            ALU_AND:  result_o = a_i & b_i;
            ALU_OR:   result_o = a_i | b_i;
            ALU_ADD:  result_o = a_i + b_i;
            ALU_SUB:  result_o = a_i - b_i;
            ALU_SLT:  result_o = {{(DATA_WIDTH_P-1){1'b0}}, slt};
            ALU_ANDN: result_o = a_i & ~b_i;
            ALU_ORN:  result_o = a_i | ~b_i;
            default:  result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/control_unit.sv
// Combinational opcode/funct decode into the datapath control bundle.
module control_unit
    import mips_pkg::*;
#(
    parameter int OP_WIDTH_P    = 6,
    parameter int FUNCT_WIDTH_P = 6
) (
    input  logic [OP_WIDTH_P-1:0]    opcode_i,
    input  logic [FUNCT_WIDTH_P-1:0] funct_i,
    output ctrl_t                    ctrl_o
);

    always_comb begin
        ctrl_o          = '0;
        ctrl_o.alu_ctrl = ALU_ADD;
        case (opcode_i)
            OP_RTYPE: begin
                ctrl_o.reg_wr_en = 1'b1;
                ctrl_o.rd_sel    = 1'b1;
                case (funct_i)
                    FN_ADD:  ctrl_o.alu_ctrl = ALU_ADD;
                    FN_SUB:  ctrl_o.alu_ctrl = ALU_SUB;
                    FN_AND:  ctrl_o.alu_ctrl = ALU_AND;
                    FN_OR:   ctrl_o.alu_ctrl = ALU_OR;
                    FN_SLT:  ctrl_o.alu_ctrl = ALU_SLT;
                    // Unknown funct must not corrupt the register file.
                    default: ctrl_o.reg_wr_en = 1'b0;
                endcase
            end
            OP_LW: begin
                ctrl_o.reg_wr_en  = 1'b1;
                ctrl_o.alu_src    = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            OP_SW: begin
                ctrl_o.alu_src = 1'b1;
                ctrl_o.mem_wr  = 1'b1;
            end
            OP_BEQ: begin
                ctrl_o.branch   = 1'b1;
                ctrl_o.alu_ctrl = ALU_SUB;
            end
            OP_ADDI: begin
                ctrl_o.reg_wr_en = 1'b1;
                ctrl_o.alu_src   = 1'b1;
            end
            OP_J:    ctrl_o.jump = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/register_file.sv
// 2-read/1-write register file; asynchronous reads, register 0 hardwired to zero.
module register_file #(
    parameter int DATA_WIDTH_P = 32,
    parameter int ADDR_WIDTH_P = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH_P-1:0] rd_addr_a_i,
    input  logic [ADDR_WIDTH_P-1:0] rd_addr_b_i,
    input  logic                    wr_en_i,
    input  logic [ADDR_WIDTH_P-1:0] wr_addr_i,
    input  logic [DATA_WIDTH_P-1:0] wr_data_i,
    output logic [DATA_WIDTH_P-1:0] rd_data_a_o,
    output logic [DATA_WIDTH_P-1:0] rd_data_b_o
);

    logic [DATA_WIDTH_P-1:0] regs_q [2**ADDR_WIDTH_P];

    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q <= '{default: '0};
        end else if (wr_en_i && (wr_addr_i != '0)) begin
            regs_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_a_o = (rd_addr_a_i == '0) ? '0 : regs_q[rd_addr_a_i];
    assign rd_data_b_o = (rd_addr_b_i == '0) ? '0 : regs_q[rd_addr_b_i];

endmodule

// File: rtl/mips_exec_slice.sv
// Single-cycle MIPS decode/execute slice: decode, register file, ALU, write-back mux.
module mips_exec_slice
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH_P      = 32,
    parameter int ADDR_WIDTH_P      = 5,
    parameter int ALU_CNTRL_WIDTH_P = 3,
    parameter int FUNCT_WIDTH_P     = 6,
    parameter int OP_WIDTH_P        = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_WIDTH_P-1:0] i_instr,
    input  logic [DATA_WIDTH_P-1:0] i_mem_rd_data,
    output logic [DATA_WIDTH_P-1:0] o_alu_result,
    output logic                    o_zero,
    output logic [DATA_WIDTH_P-1:0] o_rd_data_b,
    output logic [DATA_WIDTH_P-1:0] o_imm_ext,
    output logic                    o_mem_wr_en,
    output logic                    o_branch,
    output logic                    o_jump
);

    ctrl_t                   ctrl;
    logic [DATA_WIDTH_P-1:0] rs_data;
    logic [DATA_WIDTH_P-1:0] alu_b;
    logic [DATA_WIDTH_P-1:0] wb_data;
    logic [ADDR_WIDTH_P-1:0] wb_addr;

    assign o_imm_ext   = {{(DATA_WIDTH_P-16){i_instr[15]}}, i_instr[15:0]};
    assign alu_b       = ctrl.alu_src    ? o_imm_ext      : o_rd_data_b;
    assign wb_addr     = ctrl.rd_sel     ? i_instr[15:11] : i_instr[20:16];
    assign wb_data     = ctrl.mem_to_reg ? i_mem_rd_data  : o_alu_result;

    assign o_mem_wr_en = ctrl.mem_wr;
    assign o_branch    = ctrl.branch;
    assign o_jump      = ctrl.jump;

    control_unit #(
        .OP_WIDTH_P    (OP_WIDTH_P),
        .FUNCT_WIDTH_P (FUNCT_WIDTH_P)
    ) u_ctrl (
        .opcode_i (i_instr[31:26]),
        .funct_i  (i_instr[5:0]),
        .ctrl_o   (ctrl)
    );

    register_file #(
        .DATA_WIDTH_P (DATA_WIDTH_P),
        .ADDR_WIDTH_P (ADDR_WIDTH_P)
    ) u_rf (
        .clk         (clk),
        .reset       (reset),
        .rd_addr_a_i (i_instr[25:21]),
        .rd_addr_b_i (i_instr[20:16]),
        .wr_en_i     (ctrl.reg_wr_en),
        .wr_addr_i   (wb_addr),
        .wr_data_i   (wb_data),
        .rd_data_a_o (rs_data),
        .rd_data_b_o (o_rd_data_b)
    );

    alu #(
        .DATA_WIDTH_P      (DATA_WIDTH_P),
        .ALU_CNTRL_WIDTH_P (ALU_CNTRL_WIDTH_P)
    ) u_alu (
        .a_i      (rs_data),
        .b_i      (alu_b),
        .ctrl_i   (ctrl.alu_ctrl),
        .result_o (o_alu_result),
        .zero_o   (o_zero)
    );

endmodule

// File: tb/tb_mips_exec_slice.sv
// Bench for mips_exec_slice: directed program plus randomized instructions against an ISA-level model.
module tb_mips_exec_slice;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] i_instr;
    logic [31:0] i_mem_rd_data;
    logic [31:0] o_alu_result;
    logic        o_zero;
    logic [31:0] o_rd_data_b;
    logic [31:0] o_imm_ext;
    logic        o_mem_wr_en;
    logic        o_branch;
    logic        o_jump;

    mips_exec_slice dut (
        .clk           (clk),
        .reset         (reset),
        .i_instr       (i_instr),
        .i_mem_rd_data (i_mem_rd_data),
        .o_alu_result  (o_alu_result),
        .o_zero        (o_zero),
        .o_rd_data_b   (o_rd_data_b),
        .o_imm_ext     (o_imm_ext),
        .o_mem_wr_en   (o_mem_wr_en),
        .o_branch      (o_branch),
        .o_jump        (o_jump)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    // Architectural state and the expected outputs of the instruction being applied.
    logic [31:0] rf [32];
    logic [31:0] e_res, e_b, e_imm, e_wd;
    logic        e_zero, e_mwr, e_br, e_j, e_we;
    logic [4:0]  e_wa;

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input logic [5:0] fn);
        logic [4:0] s, t, d;
        s = rs[4:0]; t = rt[4:0]; d = rd[4:0];
        return {6'h00, s, t, d, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        logic [4:0] s, t;
        s = rs[4:0]; t = rt[4:0];
        return {op, s, t, imm};
    endfunction

    task automatic apply(input logic [31:0] ins, input logic [31:0] mem);
        logic [31:0] a, bt;
        logic [4:0]  rs, rt, rd;
        i_instr       = ins;
        i_mem_rd_data = mem;
        #1;
        rs    = ins[25:21];
        rt    = ins[20:16];
        rd    = ins[15:11];
        a     = rf[rs];
        bt    = rf[rt];
        e_imm = {{16{ins[15]}}, ins[15:0]};
        e_res = a + bt;
        e_mwr = 1'b0; e_br = 1'b0; e_j = 1'b0; e_we = 1'b0;
        e_wa  = rt;
        case (ins[31:26])
            6'h00: begin
                e_wa = rd;
                e_we = 1'b1;
                case (ins[5:0])
                    6'h20:   e_res = a + bt;
                    6'h22:   e_res = a - bt;
                    6'h24:   e_res = a & bt;
                    6'h25:   e_res = a | bt;
                    6'h2A:   e_res = ($signed(a) < $signed(bt)) ? 32'd1 : 32'd0;
                    default: e_we = 1'b0;
                endcase
            end
            6'h23: begin e_res = a + e_imm; e_we = 1'b1; end
            6'h2B: begin e_res = a + e_imm; e_mwr = 1'b1; end
            6'h04: begin e_res = a - bt; e_br = 1'b1; end
            6'h08: begin e_res = a + e_imm; e_we = 1'b1; end
            6'h02: e_j = 1'b1;
            default: ;
        endcase
        e_wd   = (ins[31:26] == 6'h23) ? mem : e_res;
        e_zero = (e_res == 32'd0);
        e_b    = bt;
    endtask

    task automatic commit();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        end else if (e_we && e_wa != 5'd0) begin
            rf[e_wa] = e_wd;
        end
        #1;
    endtask

    task automatic test_reset();
        apply(itype(6'h08, 0, 9, 16'h0055), 32'd0);
        commit();
        reset = 1'b1;
        apply(32'd0, 32'd0);
        commit();
        reset = 1'b0;
        apply(32'd0, 32'd0);
        n_chk++;
        if (o_alu_result !== 32'd0 || o_zero !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_nop got alu=%h zero=%b exp alu=0 zero=1", o_alu_result, o_zero);
        end
        for (int r = 1; r < 32; r++) begin
            apply(itype(6'h2B, 0, r, 16'h0), 32'd0);
            n_chk++;
            if (o_rd_data_b !== 32'd0) begin
                n_bad++;
                $display("FAIL reset_reg r%0d got=%h exp=0", r, o_rd_data_b);
            end
        end
    endtask

    task automatic test_arith();
        apply(32'h20010005, 32'd0); commit();
        apply(32'h00211820, 32'd0);
        n_chk++;
        if (o_alu_result !== 32'd10) begin
            n_bad++; $display("FAIL add_result got=%h exp=%h", o_alu_result, 32'd10);
        end
        commit();
        apply(itype(6'h2B, 0, 3, 16'h0), 32'd0);
        n_chk++;
        if (o_rd_data_b !== 32'd10) begin
            n_bad++; $display("FAIL add_wb got=%h exp=%h", o_rd_data_b, 32'd10);
        end
        apply(32'h2002FFFD, 32'd0); commit();
        apply(rtype(1, 2, 4, 6'h22), 32'd0);
        n_chk++;
        if (o_alu_result !== 32'd8) begin
            n_bad++; $display("FAIL sub got=%h exp=%h", o_alu_result, 32'd8);
        end
        commit();
        apply(rtype(2, 1, 5, 6'h2A), 32'd0);
        n_chk++;
        if (o_alu_result !== 32'd1) begin
            n_bad++; $display("FAIL slt_true got=%h exp=1", o_alu_result);
        end
        commit();
        apply(rtype(1, 2, 5, 6'h2A), 32'd0);
        n_chk++;
        if (o_alu_result !== 32'd0 || o_zero !== 1'b1) begin
            n_bad++; $display("FAIL slt_false got=%h zero=%b exp=0 zero=1", o_alu_result, o_zero);
        end
        commit();
        apply(itype(6'h23, 0, 7, 16'h0), 32'hF0F0F0F0); commit();
        apply(itype(6'h23, 0, 8, 16'h0), 32'h0FF00FF0); commit();
        apply(rtype(7, 8, 9, 6'h24), 32'd0);
        n_chk++;
        if (o_alu_result !== 32'h00F000F0) begin
            n_bad++; $display("FAIL and got=%h exp=%h", o_alu_result, 32'h00F000F0);
        end
        commit();
        apply(rtype(7, 8, 10, 6'h25), 32'd0);
        n_chk++;
        if (o_alu_result !== 32'hFFF0FFF0) begin
            n_bad++; $display("FAIL or got=%h exp=%h", o_alu_result, 32'hFFF0FFF0);
        end
        commit();
        // Read-during-write of $1 must see the value before the edge.
        apply(rtype(1, 1, 1, 6'h20), 32'd0);
        n_chk++;
        if (o_rd_data_b !== 32'd5 || o_alu_result !== 32'd10) begin
            n_bad++; $display("FAIL rw_same got b=%h alu=%h exp b=5 alu=a", o_rd_data_b, o_alu_result);
        end
        commit();
        apply(itype(6'h2B, 0, 1, 16'h0), 32'd0);
        n_chk++;
        if (o_rd_data_b !== 32'd10) begin
            n_bad++; $display("FAIL rw_after got=%h exp=a", o_rd_data_b);
        end
        apply(32'h20010005, 32'd0); commit();
    endtask

    task automatic test_mem();
        apply(32'h8C26FFFC, 32'hDEADBEEF);
        n_chk++;
        if (o_imm_ext !== 32'hFFFFFFFC || o_alu_result !== 32'd1 || o_mem_wr_en !== 1'b0) begin
            n_bad++; $display("FAIL lw got imm=%h alu=%h mwr=%b exp imm=fffffffc alu=1 mwr=0",
                              o_imm_ext, o_alu_result, o_mem_wr_en);
        end
        commit();
        apply(32'hAC060000, 32'h12345678);
        n_chk++;
        if (o_mem_wr_en !== 1'b1 || o_rd_data_b !== 32'hDEADBEEF || o_alu_result !== 32'd0) begin
            n_bad++; $display("FAIL sw got mwr=%b b=%h alu=%h exp mwr=1 b=deadbeef alu=0",
                              o_mem_wr_en, o_rd_data_b, o_alu_result);
        end
        commit();
    endtask

    task automatic test_branch_jump();
        apply(32'h10210000, 32'd0);
        n_chk++;
        if (o_branch !== 1'b1 || o_zero !== 1'b1 || o_jump !== 1'b0 || o_mem_wr_en !== 1'b0) begin
            n_bad++; $display("FAIL beq got br=%b zero=%b j=%b mwr=%b exp 1 1 0 0", o_branch, o_zero, o_jump, o_mem_wr_en);
        end
        commit();
        apply(32'h08000010, 32'd0);
        n_chk++;
        if (o_jump !== 1'b1 || o_branch !== 1'b0 || o_mem_wr_en !== 1'b0) begin
            n_bad++; $display("FAIL j got j=%b br=%b mwr=%b exp 1 0 0", o_jump, o_branch, o_mem_wr_en);
        end
        commit();
        apply({6'h3F, 5'd1, 5'd11, 16'h0007}, 32'hCAFEF00D);
        n_chk++;
        if (o_jump !== 1'b0 || o_branch !== 1'b0 || o_mem_wr_en !== 1'b0) begin
            n_bad++; $display("FAIL undef_op got j=%b br=%b mwr=%b exp 0 0 0", o_jump, o_branch, o_mem_wr_en);
        end
        commit();
        apply(rtype(1, 1, 12, 6'h3F), 32'd0); commit();
        for (int r = 1; r < 32; r++) begin
            apply(itype(6'h2B, 0, r, 16'h0), 32'd0);
            n_chk++;
            if (o_rd_data_b !== rf[r]) begin
                n_bad++; $display("FAIL no_write r%0d got=%h exp=%h", r, o_rd_data_b, rf[r]);
            end
        end
    endtask

    task automatic test_r0();
        apply(32'h20000007, 32'd0); commit();
        apply(itype(6'h2B, 0, 0, 16'h0), 32'd0);
        n_chk++;
        if (o_rd_data_b !== 32'd0) begin
            n_bad++; $display("FAIL r0 got=%h exp=0", o_rd_data_b);
        end
    endtask

    task automatic test_random();
        logic [31:0] ins;
        logic [5:0]  ops [7];
        logic [5:0]  fns [6];
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02, 6'h3F};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h07};
        for (int n = 0; n < 300; n++) begin
            ins = $urandom;
            ins[31:26] = ops[$urandom_range(0, 6)];
            ins[5:0]   = fns[$urandom_range(0, 5)];
            apply(ins, $urandom);
            n_chk++;
            if ((ins[31:26] != 6'h02 && (o_alu_result !== e_res || o_zero !== e_zero)) ||
                o_rd_data_b !== e_b || o_imm_ext !== e_imm || o_mem_wr_en !== e_mwr ||
                o_branch !== e_br || o_jump !== e_j) begin
                n_bad++;
                $display("FAIL random ins=%h got alu=%h z=%b b=%h imm=%h mwr=%b br=%b j=%b exp alu=%h z=%b b=%h imm=%h mwr=%b br=%b j=%b",
                         ins, o_alu_result, o_zero, o_rd_data_b, o_imm_ext, o_mem_wr_en, o_branch, o_jump,
                         e_res, e_zero, e_b, e_imm, e_mwr, e_br, e_j);
            end
            commit();
        end
    endtask

    task automatic test_reset_write();
        apply(itype(6'h08, 0, 7, 16'h0009), 32'd0);
        commit();
        reset = 1'b1;
        apply(itype(6'h08, 0, 7, 16'h0011), 32'd0);
        commit();
        reset = 1'b0;
        apply(itype(6'h2B, 0, 7, 16'h0), 32'd0);
        n_chk++;
        if (o_rd_data_b !== 32'd0) begin
            n_bad++; $display("FAIL reset_write got=%h exp=0", o_rd_data_b);
        end
    endtask

    initial begin
        reset         = 1'b1;
        i_instr       = 32'd0;
        i_mem_rd_data = 32'd0;
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        test_reset();
        test_arith();
        test_mem();
        test_branch_jump();
        test_r0();
        test_random();
        test_reset_write();
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
